// File: rtl/seq_div_16by8.sv
// Signed 2N/N restoring divider with a start/rdy handshake: a result lands 2N+1 cycles after an accepted start, or 1 cycle for divide-by-zero.
// start is accepted only in IDLE and ignored while busy. DIV_SAT_EN, when defined, saturates quot on overflow.
module seq_div_16by8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quot,
  output logic [N-1:0]   rem,
  output logic           rdy,
  output logic           busy,
  output logic           div_by_zero,
  output logic           ovf
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_ITER = CW'(2 * N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*N-1:0] r_dvd;
  logic [N-1:0]   r_dvs;
  logic [N:0]     r_prem;
  logic [2*N-1:0] r_qmag;
  logic [CW-1:0]  r_cnt;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dbz;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_rdy;
  logic           r_busy;
  logic           r_dbz_o;
  logic           r_ovf;

  logic [2*N-1:0] w_dvd_abs;
  logic [N-1:0]   w_dvs_abs;
  logic [N:0]     w_trial;
  logic [N:0]     w_diff;
  logic           w_ge;
  logic [2*N:0]   w_qs;
  logic           w_ovf;
  logic [N-1:0]   w_quot;
  logic [N-1:0]   w_rem;

  assign w_dvd_abs = dividend[2*N-1] ? -dividend : dividend;
  assign w_dvs_abs = divisor[N-1]    ? -divisor  : divisor;

  assign w_trial = {r_prem[N-1:0], r_dvd[2*N-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial - {1'b0, r_dvs};

  // One extra bit so +2^(2N-1) (e.g. 0x8000 / -1) is not mistaken for a negative quotient.
  assign w_qs  = r_neg_q ? -{1'b0, r_qmag} : {1'b0, r_qmag};
  assign w_ovf = ~((&w_qs[2*N:N-1]) | ~(|w_qs[2*N:N-1]));
  assign w_rem = r_neg_r ? -r_prem[N-1:0] : r_prem[N-1:0];

`ifdef DIV_SAT_EN
  assign w_quot = w_ovf ? (r_neg_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                        : w_qs[N-1:0];
`else
  assign w_quot = w_qs[N-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (divisor == '0) ? FIX : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == LAST_ITER) begin
          w_next = FIX;
        end
      end
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_qmag  <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_dbz_o <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_neg_q <= dividend[2*N-1] ^ divisor[N-1];
            r_neg_r <= dividend[2*N-1];
            r_dbz   <= (divisor == '0);
            r_prem  <= '0;
            r_qmag  <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_dbz_o <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= (divisor != '0);
          end
        end
        BUSY: begin
          r_prem <= w_ge ? w_diff : w_trial;
          r_qmag <= {r_qmag[2*N-2:0], w_ge};
          r_dvd  <= {r_dvd[2*N-2:0], 1'b0};
          r_cnt  <= r_cnt + CW'(1);
        end
        FIX: begin
          if (r_dbz) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
            r_dbz_o <= 1'b1;
          end else begin
            r_quot  <= w_quot;
            r_rem   <= w_rem;
            r_ovf   <= w_ovf;
            r_dbz_o <= 1'b0;
          end
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign quot        = r_quot;
  assign rem         = r_rem;
  assign rdy         = r_rdy;
  assign busy        = r_busy;
  assign div_by_zero = r_dbz_o;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed-vector bench for seq_div_16by8; expected quotients follow DIV_SAT_EN when it is defined.
module tb_seq_div_16by8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        rdy;
  logic        busy;
  logic        div_by_zero;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef DIV_SAT_EN
  localparam logic [7:0] Q_4000_01 = 8'h7F;
  localparam logic [7:0] Q_8000_FF = 8'h7F;
  localparam logic [7:0] Q_7FFF_80 = 8'h80;
  localparam logic [7:0] Q_8000_80 = 8'h7F;
`else
  localparam logic [7:0] Q_4000_01 = 8'h00;
  localparam logic [7:0] Q_8000_FF = 8'h00;
  localparam logic [7:0] Q_7FFF_80 = 8'h01;
  localparam logic [7:0] Q_8000_80 = 8'h00;
`endif

  seq_div_16by8 #(.N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quot        (quot),
    .rem         (rem),
    .rdy         (rdy),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic launch(input string tag, input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rdy_e0"}, 16'(rdy), 16'd0);
    chk({tag, "_busy_e0"}, 16'(busy), 16'(b != 8'h00));
    start = 1'b0;
  endtask

  task automatic wait_rdy(input int pulse_at, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        lat = i;
        break;
      end
      if (i == pulse_at) begin
        dividend = 16'h1234;
        divisor  = 8'h01;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic div_vec(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic eovf, input logic edbz);
    int lat;
    launch(tag, a, b);
    wait_rdy(0, lat);
    chk({tag, "_lat"}, 16'(lat), edbz ? 16'd1 : 16'd17);
    chk({tag, "_quot"}, 16'(quot), 16'(eq));
    chk({tag, "_rem"}, 16'(rem), 16'(er));
    chk({tag, "_ovf"}, 16'(ovf), 16'(eovf));
    chk({tag, "_dbz"}, 16'(div_by_zero), 16'(edbz));
    chk({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int lat;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 8'h00;
    #12;
    chk("rst_quot", 16'(quot), 16'd0);
    chk("rst_rem", 16'(rem), 16'd0);
    chk("rst_rdy", 16'(rdy), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_dbz", 16'(div_by_zero), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    div_vec("p100_p7",  16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0);
    div_vec("n100_p7",  16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
    div_vec("n100_n7",  16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
    div_vec("dbz",      16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    div_vec("ovf_4000", 16'h4000, 8'h01, Q_4000_01, 8'h00, 1'b1, 1'b0);
    div_vec("ovf_8000", 16'h8000, 8'hFF, Q_8000_FF, 8'h00, 1'b1, 1'b0);
    div_vec("min_ff80", 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
    div_vec("ovf_7fff", 16'h7FFF, 8'h80, Q_7FFF_80, 8'h7F, 1'b1, 1'b0);
    div_vec("ovf_8080", 16'h8000, 8'h80, Q_8000_80, 8'h00, 1'b1, 1'b0);
    div_vec("max_c080", 16'hC080, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b0);
    div_vec("neg_3f80", 16'h3F80, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0);
    div_vec("zero_dvd", 16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);

    // A start pulse mid-divide must neither restart nor re-capture operands.
    launch("ign", 16'h0064, 8'h07);
    wait_rdy(5, lat);
    chk("ign_lat", 16'(lat), 16'd17);
    chk("ign_quot", 16'(quot), 16'h000E);
    chk("ign_rem", 16'(rem), 16'h0002);

    launch("abort", 16'hFF9C, 8'h07);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_quot", 16'(quot), 16'd0);
    chk("abort_rem", 16'(rem), 16'd0);
    chk("abort_rdy", 16'(rdy), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_dbz", 16'(div_by_zero), 16'd0);
    chk("abort_ovf", 16'(ovf), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    div_vec("post_rst", 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_div_16by8.md
Name: seq_div_16by8

Overview:
Multi-cycle signed restoring divider that pairs with the sequential 8-bit multiplier. It divides a 16-bit two's-complement dividend (a full-width product) by an 8-bit two's-complement divisor. Outputs are an 8-bit quotient and an 8-bit remainder, with a start/rdy handshake. It sits beside the multiplier in the arithmetic unit and recovers a factor from a product.

Parameters:
N, 8, divisor/quotient/remainder width; dividend width is 2*N; iteration count is 2*N.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  2N  signed dividend, captured on accepted start
divisor  input  N  signed divisor, captured on accepted start
quot  output  N  signed quotient, truncated toward zero
rem  output  N  signed remainder, same sign as dividend
rdy  output  1  result valid; held until next accepted start
busy  output  1  operation in progress
div_by_zero  output  1  divisor was 0
ovf  output  1  true quotient outside [-2^(N-1), 2^(N-1)-1]

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. Reset forces state IDLE and quot=rem=0, rdy=busy=div_by_zero=ovf=0. Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, BUSY, FIX.
- IDLE, start=1 at edge E0:
  - Capture operands; store magnitudes |dividend| (16-bit unsigned) and |divisor| (8-bit unsigned); store signs; clear rdy, div_by_zero and ovf.
  - If divisor==0: go to FIX with the dbz flag set.
  - Otherwise: clear the partial remainder (N+1 bits) and the iteration counter, set busy=1, go to BUSY.
- BUSY, edges E1..E16, one iteration per cycle:
  - Shift the dividend-magnitude MSB into the partial remainder.
  - If partial remainder >= |divisor|: subtract, quotient bit=1; else quotient bit=0.
  - Quotient magnitude is 2N bits wide.
  - After iteration 2N, go to FIX.
- FIX, edge E17 (E1 for divide-by-zero):
  - Negate the quotient magnitude if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Register quot, rem and ovf; set rdy=1, busy=0; return to IDLE.
  - Divide-by-zero: quot=0, rem=0, div_by_zero=1, ovf=0.
- Latency: rdy is high after edge E17 (17 cycles) for a normal divide, after edge E1 for divide-by-zero.
- Outputs hold while in IDLE until the next accepted start. rdy falls on that start edge.
- start while busy=1 is ignored; the operands are not re-captured.
- Boundary operands:
  - dividend 0x8000 has magnitude 32768, representable in the 16-bit magnitude.
  - divisor 0x80 has magnitude 128, representable in 8 bits.
  - Partial remainder is N+1 bits, so no loss.
- Overflow check uses the 2N-bit signed quotient against the N-bit signed range. On ovf (non-saturating build), quot = low N bits of the two's-complement quotient; rem is still exact.

Optional Feature:
DIV_SAT_EN:
- Defined: on ovf=1, quot saturates to 0x7F (positive result) or 0x80 (negative result).
- Undefined: quot = low N bits of the quotient.
- ovf flag behaviour is identical in both builds.

Test Plan:
- dividend=0x0064 (100), divisor=0x07, start 1 cycle -> after 17 cycles rdy=1, quot=0x0E, rem=0x02, ovf=0, busy low.
- dividend=0xFF9C (-100), divisor=0x07 -> quot=0xF2 (-14), rem=0xFE (-2). Same dividend with divisor=0xF9 (-7) -> quot=0x0E, rem=0xFE.
- dividend=0x1234, divisor=0x00 -> next cycle rdy=1, div_by_zero=1, quot=0, rem=0; busy never asserted.
- dividend=0x4000, divisor=0x01 -> ovf=1, quot=0x00 (0x7F with DIV_SAT_EN).
  - dividend=0x8000, divisor=0xFF -> ovf=1.
  - dividend=0xFF80, divisor=0x01 -> quot=0x80, ovf=0.
- Start a divide, pulse start with new operands at cycle 5 -> ignored; original result delivered at cycle 17.
- Start a divide, assert reset at cycle 8 -> all outputs 0 immediately. A new start then completes normally.
